mem_arbiter_rr: RTL and testbench

Parametrised N-channel arbiter between cache/VGA requesters and the DDR2 memory controller. It is the successor to the fixed 3-port priority arbiter and adds:
- selectable round-robin or fixed priority
- per-request latching of address, data and direction
- a watchdog timeout with an error response
- generic widths and address mapping

It sits between the I-cache, D-cache, VGA and other requesters and the memory-controller user interface.

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/mem_arbiter_rr_if.sv | 36 +++
 rtl/rr_pick.sv | 42 ++++
 rtl/mem_arbiter_rr.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter_rr.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types, default widths and address mapping for the memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DATA_W  = 256;
  localparam int CADDR_W = 28;
  localparam int MADDR_W = 31;

  // Wide enough for any requester or controller address this block supports.
  localparam int MAP_W = 64;

  // Forward addr[lsb +: bits] to the controller, zero above.
  function automatic logic [MAP_W-1:0] map_addr(
    input logic [MAP_W-1:0] addr,
    input int               lsb,
    input int               bits
  );
    logic [MAP_W-1:0] mask;
    mask = (bits >= MAP_W) ? '1 : ((MAP_W'(1) << bits) - MAP_W'(1));
    return (addr >> lsb) & mask;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_if.sv
// Requester and memory-controller bundle for the arbiter.
// Latency: n/a (wires only).
// Backpressure: completion pulses (req_ready) and controller handshakes travel here.
interface mem_arbiter_rr_if #(
  parameter int NUM_CH  = 3,
  parameter int DATA_W  = mem_arb_pkg::DATA_W,
  parameter int CADDR_W = mem_arb_pkg::CADDR_W,
  parameter int MADDR_W = mem_arb_pkg::MADDR_W
);
  logic [NUM_CH-1:0]         req_valid;
  logic [NUM_CH-1:0]         req_rw;
  logic [NUM_CH*CADDR_W-1:0] req_addr;
  logic [NUM_CH*DATA_W-1:0]  req_wdata;
  logic [NUM_CH-1:0]         req_ready;
  logic [NUM_CH-1:0]         req_err;
  logic [DATA_W-1:0]         rsp_rdata;
  logic [DATA_W-1:0]         data_wr;
  logic [MADDR_W-1:0]        data_addr;
  logic [DATA_W-1:0]         data_rd;
  logic                      data_rden;
  logic                      data_wren;
  logic                      mc_rd_valid;
  logic                      mc_wr_rdy;

  // Arbiter side.
  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata, data_rd, mc_rd_valid, mc_wr_rdy,
    output req_ready, req_err, rsp_rdata, data_wr, data_addr, data_rden, data_wren
  );

  // Requester/controller side.
  modport master (
    output req_valid, req_rw, req_addr, req_wdata, data_rd, mc_rd_valid, mc_wr_rdy,
    input  req_ready, req_err, rsp_rdata, data_wr, data_addr, data_rden, data_wren
  );
endinterface

// File: rtl/rr_pick.sv
// Round-robin / fixed-priority picker over NUM_CH request lines.
// Latency: combinational.
// Backpressure: none; the caller decides when a pick is consumed.
module rr_pick #(
  parameter int NUM_CH = 3,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  last,
  input  logic              mode,
  output logic [IDX_W-1:0]  grant,
  output logic              any_valid
);
  logic [IDX_W-1:0]  start;
  logic [NUM_CH-1:0] scan;
  logic [IDX_W-1:0]  cnt;
  logic [IDX_W-1:0]  off;
  logic              found;
  logic [IDX_W:0]    sum;

  // Rotate the request vector to the search start, take the lowest set bit, rotate back.
  always_comb begin
    start = '0;
    if (mode && (last != IDX_W'(NUM_CH - 1))) start = last + 1'b1;
    scan  = NUM_CH'({req, req} >> start);
    cnt   = '0;
    off   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && scan[0]) begin
        found = 1'b1;
        off   = cnt;
      end
      scan = scan >> 1;
      cnt  = cnt + 1'b1;
    end
    sum = {1'b0, start} + {1'b0, off};
    if (sum >= (IDX_W+1)'(NUM_CH)) sum = sum - (IDX_W+1)'(NUM_CH);
    grant     = sum[IDX_W-1:0];
    any_valid = |req;
  end
endmodule

// File: rtl/mem_arbiter_rr.sv
// N-channel arbiter in front of the DDR2 controller user interface (RR or fixed priority).
// Latency: req_valid -> rden/wren 1 cycle; completion -> req_ready 1 cycle; 1 turnaround cycle after.
// Backpressure: one command in flight; other requesters wait until req_ready, watchdog aborts stalls.
module mem_arbiter_rr #(
  parameter int NUM_CH      = 3,
  parameter int DATA_W      = mem_arb_pkg::DATA_W,
  parameter int CADDR_W     = mem_arb_pkg::CADDR_W,
  parameter int MADDR_W     = mem_arb_pkg::MADDR_W,
  parameter int ADDR_LSB    = 1,
  parameter int ADDR_BITS   = 25,
  parameter int RR_MODE     = 1,
  parameter int TIMEOUT_CYC = 1023
) (
  input logic            clk,
  input logic            reset,
  mem_arbiter_rr_if.slave bus
);
  import mem_arb_pkg::*;

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int TMR_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic               rw_q, rw_d;
  logic [MADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]  wdat_q, wdat_d;
  logic               rden_q, rden_d;
  logic               wren_q, wren_d;
  logic [NUM_CH-1:0]  ready_q, ready_d;
  logic [NUM_CH-1:0]  err_q, err_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [TMR_W-1:0]   timer_q, timer_d;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [NUM_CH-1:0]  grant_oh;
  logic               timeout_hit;

  logic [CADDR_W-1:0] ch_addr  [NUM_CH];
  logic [DATA_W-1:0]  ch_wdata [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign ch_addr[i]  = bus.req_addr[i*CADDR_W +: CADDR_W];
    assign ch_wdata[i] = bus.req_wdata[i*DATA_W +: DATA_W];
  end

  rr_pick #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_pick (
    .req       (bus.req_valid),
    .last      (last_q),
    .mode      (RR_MODE != 0),
    .grant     (pick_idx),
    .any_valid (pick_any)
  );

  assign grant_oh    = NUM_CH'(1) << grant_q;
  // The count includes the current BUSY cycle, so the abort lands on cycle TIMEOUT_CYC.
  assign timeout_hit = (TIMEOUT_CYC != 0) && ((timer_q + 1'b1) == TMR_W'(TIMEOUT_CYC));

  // Next-state and next-register values; completion beats a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    rden_d  = rden_q;
    wren_d  = wren_q;
    ready_d = '0;
    err_d   = '0;
    rdata_d = rdata_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          rw_d    = bus.req_rw[pick_idx];
          addr_d  = MADDR_W'(map_addr(64'(ch_addr[pick_idx]), ADDR_LSB, ADDR_BITS));
          wdat_d  = ch_wdata[pick_idx];
          rden_d  = !bus.req_rw[pick_idx];
          wren_d  = bus.req_rw[pick_idx];
          timer_d = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        timer_d = timer_q + 1'b1;
        if (!rw_q && bus.mc_rd_valid) begin
          rdata_d = bus.data_rd;
          rden_d  = 1'b0;
          ready_d = grant_oh;
          state_d = DONE;
        end else if (rw_q && bus.mc_wr_rdy) begin
          wren_d  = 1'b0;
          ready_d = grant_oh;
          state_d = DONE;
        end else if (timeout_hit) begin
          rden_d  = 1'b0;
          wren_d  = 1'b0;
          ready_d = grant_oh;
          err_d   = grant_oh;
          state_d = DONE;
        end
      end
      DONE: begin
        last_d  = grant_q;
        timer_d = '0;
        addr_d  = '0;
        wdat_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset; reset drops enables with no response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_CH - 1);
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      rden_q  <= 1'b0;
      wren_q  <= 1'b0;
      ready_q <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rden_q  <= rden_d;
      wren_q  <= wren_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      timer_q <= timer_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.req_err   = err_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.data_wr   = wdat_q;
  assign bus.data_addr = addr_q;
  assign bus.data_rden = rden_q;
  assign bus.data_wren = wren_q;
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: RR instance with an 8-cycle watchdog, fixed-priority instance without one.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: controller handshakes are driven by the bench.
module tb_mem_arbiter_rr;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_rr_if #(.NUM_CH(3), .DATA_W(256), .CADDR_W(28), .MADDR_W(31)) bif ();
  mem_arbiter_rr_if #(.NUM_CH(3), .DATA_W(256), .CADDR_W(28), .MADDR_W(31)) fif ();

  mem_arbiter_rr #(.NUM_CH(3), .DATA_W(256), .CADDR_W(28), .MADDR_W(31), .ADDR_LSB(1),
                   .ADDR_BITS(25), .RR_MODE(1), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .reset(reset), .bus(bif));

  mem_arbiter_rr #(.NUM_CH(3), .DATA_W(256), .CADDR_W(28), .MADDR_W(31), .ADDR_LSB(1),
                   .ADDR_BITS(25), .RR_MODE(0), .TIMEOUT_CYC(0)) dut_fp (
    .clk(clk), .reset(reset), .bus(fif));

  int vectors = 0;
  int miscompares = 0;

  // Reference state: last granted channel and last delivered read data.
  int           model_last;
  logic [255:0] model_rsp;

  logic [2:0]   t_rw;
  logic [27:0]  t_addr [3];
  logic [255:0] t_wd   [3];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int w = 0; w < 8; w++) v = {v[223:0], 32'($urandom)};
    return v;
  endfunction

  // Controller address: requester bits [25:1], zero above.
  function automatic logic [30:0] exp_map(input logic [27:0] a);
    return 31'((a >> 1) & 28'h1FF_FFFF);
  endfunction

  // First requesting channel after 'last' (wrapping), or lowest index in fixed mode.
  function automatic int model_pick(input logic [2:0] v, input int last, input bit rr);
    logic [2:0] t;
    int c;
    for (int k = 1; k <= 3; k++) begin
      c = rr ? (last + k) % 3 : k - 1;
      t = v >> c;
      if (t[0]) return c;
    end
    return -1;
  endfunction

  task automatic apply();
    bif.req_rw    = t_rw;
    bif.req_addr  = {t_addr[2], t_addr[1], t_addr[0]};
    bif.req_wdata = {t_wd[2], t_wd[1], t_wd[0]};
  endtask

  task automatic rand_fields();
    for (int i = 0; i < 3; i++) begin
      t_rw[2'(i)]   = 1'($urandom_range(0, 1));
      t_addr[2'(i)] = 28'($urandom);
      t_wd[2'(i)]   = rnd256();
    end
    apply();
  endtask

  // Wrong-direction handshakes that the arbiter must ignore.
  task automatic noise(input logic xrw);
    bif.data_rd = rnd256();
    if (xrw) begin
      bif.mc_rd_valid = 1'($urandom_range(0, 1));
      bif.mc_wr_rdy   = 1'b0;
    end else begin
      bif.mc_wr_rdy   = 1'($urandom_range(0, 1));
      bif.mc_rd_valid = 1'b0;
    end
  endtask

  // One transaction on the RR instance, starting on a falling edge with the arbiter idle.
  // lat = wait cycles before the handshake; to_case = never answer (lat must then be 7).
  task automatic txn(input logic [2:0] vmask, input int lat, input bit to_case,
                     input bit drop_mid, input logic [255:0] rd);
    int g;
    logic xrw;
    logic [30:0] xaddr;
    logic [255:0] xwd;
    logic [2:0] oh;
    apply();
    bif.req_valid = vmask;
    g     = model_pick(vmask, model_last, 1'b1);
    xrw   = t_rw[2'(g)];
    xaddr = exp_map(t_addr[2'(g)]);
    xwd   = t_wd[2'(g)];
    oh    = 3'b001 << g;
    @(negedge clk);
    chk("en_rd", 256'(bif.data_rden), 256'(!xrw));
    chk("en_wr", 256'(bif.data_wren), 256'(xrw));
    chk("addr", 256'(bif.data_addr), 256'(xaddr));
    chk("wdata", bif.data_wr, xwd);
    rand_fields();
    bif.req_valid = drop_mid ? (vmask & ~oh) : vmask;
    for (int c = 0; c < lat; c++) begin
      noise(xrw);
      @(negedge clk);
      chk("en_hold", 256'({bif.data_rden, bif.data_wren}), 256'({!xrw, xrw}));
      chk("addr_hold", 256'(bif.data_addr), 256'(xaddr));
      chk("rdy_wait", 256'(bif.req_ready), 256'(0));
    end
    noise(xrw);
    if (!to_case) begin
      if (xrw) bif.mc_wr_rdy = 1'b1;
      else begin
        bif.mc_rd_valid = 1'b1;
        bif.data_rd     = rd;
      end
    end
    @(negedge clk);
    bif.mc_rd_valid = 1'b0;
    bif.mc_wr_rdy   = 1'b0;
    if (!to_case && !xrw) model_rsp = rd;
    chk("ready", 256'(bif.req_ready), 256'(oh));
    chk("err", 256'(bif.req_err), to_case ? 256'(oh) : 256'(0));
    chk("en_off", 256'({bif.data_rden, bif.data_wren}), 256'(0));
    chk("rsp", bif.rsp_rdata, model_rsp);
    model_last = g;
    @(negedge clk);
    chk("ready_pulse", 256'({bif.req_ready, bif.req_err}), 256'(0));
    chk("turnaround", 256'({bif.data_rden, bif.data_wren, bif.data_addr}), 256'(0));
    chk("wdata_clr", bif.data_wr, 256'(0));
  endtask

  initial begin
    logic [27:0] fa0, fa2;
    bif.req_valid = '0; bif.mc_rd_valid = 1'b0; bif.mc_wr_rdy = 1'b0; bif.data_rd = '0;
    fif.req_valid = '0; fif.mc_rd_valid = 1'b0; fif.mc_wr_rdy = 1'b0; fif.data_rd = '0;
    fif.req_rw = '0; fif.req_addr = '0; fif.req_wdata = '0;
    t_rw = '0;
    for (int i = 0; i < 3; i++) begin t_addr[2'(i)] = '0; t_wd[2'(i)] = '0; end
    apply();
    model_last = 2;
    model_rsp  = '0;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_ctl", 256'({bif.req_ready, bif.req_err, bif.data_rden, bif.data_wren}), 256'(0));
    chk("rst_addr", 256'(bif.data_addr), 256'(0));
    chk("rst_rsp", bif.rsp_rdata, 256'(0));
    chk("rst_fp", 256'({fif.req_ready, fif.data_wren, fif.data_rden}), 256'(0));
    reset = 1'b0;

    // Single read on ch1 with the documented address mapping; reply after 5 wait cycles.
    t_rw[1] = 1'b0; t_addr[1] = 28'h00000A6; t_wd[1] = rnd256();
    txn(3'b010, 5, 1'b0, 1'b0, {8{32'hDEADBEEF}});
    chk("map_0a6", 256'(exp_map(28'h00000A6)), 256'(31'h53));

    // Round robin with all three channels writing continuously.
    for (int r = 0; r < 6; r++) begin
      t_rw = 3'b111;
      txn(3'b111, 1 + r % 2, 1'b0, 1'b0, rnd256());
    end

    // Watchdog on a read, then a write answered exactly in the watchdog cycle.
    t_rw[1] = 1'b0;
    txn(3'b010, 7, 1'b1, 1'b0, rnd256());
    t_rw[0] = 1'b1;
    txn(3'b001, 7, 1'b0, 1'b0, rnd256());
    t_rw[0] = 1'b0;
    txn(3'b001, 7, 1'b0, 1'b0, rnd256());

    // ch2 drops valid mid-transaction, with spurious read-valid noise during a write.
    t_rw[2] = 1'b1;
    txn(3'b100, 4, 1'b0, 1'b1, rnd256());

    // Reset in the middle of a write.
    t_rw[0] = 1'b1; apply();
    bif.req_valid = 3'b001;
    @(negedge clk);
    chk("rst_wren_on", 256'(bif.data_wren), 256'(1));
    @(negedge clk);
    reset = 1'b1;
    bif.mc_wr_rdy = 1'b1;
    @(negedge clk);
    chk("rst_mid_en", 256'({bif.data_wren, bif.data_rden}), 256'(0));
    chk("rst_mid_rdy", 256'({bif.req_ready, bif.req_err}), 256'(0));
    bif.mc_wr_rdy = 1'b0;
    reset = 1'b0;
    model_last = 2;
    model_rsp  = '0;
    rand_fields();
    txn(3'b111, 2, 1'b0, 1'b0, rnd256());

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      logic [2:0] vm;
      bit tc;
      vm = 3'($urandom_range(1, 7));
      tc = ($urandom_range(0, 5) == 0);
      txn(vm, tc ? 7 : int'($urandom_range(0, 7)), tc, 1'($urandom_range(0, 1)), rnd256());
    end
    bif.req_valid = '0;

    // Fixed priority: ch0 always beats ch2; the disabled watchdog never aborts.
    fa0 = 28'($urandom); fa2 = 28'($urandom);
    fif.req_rw    = 3'b111;
    fif.req_addr  = {fa2, 28'h0, fa0};
    fif.req_wdata = {rnd256(), rnd256(), rnd256()};
    fif.req_valid = 3'b101;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      chk("fp_wren", 256'(fif.data_wren), 256'(1));
      chk("fp_addr", 256'(fif.data_addr), 256'(exp_map(fa0)));
      fif.mc_wr_rdy = 1'b1;
      @(negedge clk);
      fif.mc_wr_rdy = 1'b0;
      chk("fp_ready", 256'(fif.req_ready), 256'(model_pick(3'b101, 0, 1'b0) == 0 ? 3'b001 : 3'b100));
      @(negedge clk);
    end
    fif.req_valid = 3'b100;
    @(negedge clk);
    chk("fp_addr2", 256'(fif.data_addr), 256'(exp_map(fa2)));
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("fp_nowd", 256'({fif.data_wren, fif.req_ready, fif.req_err}), 256'({1'b1, 6'b0}));
    end
    fif.mc_wr_rdy = 1'b1;
    @(negedge clk);
    fif.mc_wr_rdy = 1'b0;
    fif.req_valid = '0;
    chk("fp_ready2", 256'({fif.req_ready, fif.req_err}), 256'({3'b100, 3'b000}));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
